// File: rtl/fcmp_wb_buffer.sv
// Compare-result buffer ahead of FPU writeback: DEPTH-entry in-order FIFO, sticky NV from retired entries.
// Latency 1 (0 on an empty buffer when FCMP_WB_BYPASS_EN is defined); InReady drops only when full, no ready-through.
module fcmp_wb_buffer #(
    parameter int FLEN  = 64,
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [FLEN-1:0]          InFpRes,
    input  logic [XLEN-1:0]          InIntRes,
    input  logic                     InToInt,
    input  logic                     InNV,
    input  logic [4:0]               InRd,
    input  logic                     Flush,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [FLEN-1:0]          OutFpRes,
    output logic [XLEN-1:0]          OutIntRes,
    output logic                     OutToInt,
    output logic [4:0]               OutRd,
    output logic                     OutNV,
    output logic                     StickyNV,
    input  logic                     StickyClr,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [FLEN-1:0] fp_res;
        logic [XLEN-1:0] int_res;
        logic            to_int;
        logic            nv;
        logic [4:0]      rd;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sticky_q, sticky_d;
    entry_t        in_ent, head_ent, out_ent;
    logic          full, empty, enq, deq, byp;

    assign in_ent   = '{fp_res: InFpRes, int_res: InIntRes, to_int: InToInt, nv: InNV, rd: InRd};
    assign head_ent = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

`ifdef FCMP_WB_BYPASS_EN
    // An empty buffer with a ready consumer hands the input straight through without storing it.
    assign byp     = empty & InValid & OutReady & ~Flush;
    assign out_ent = byp ? in_ent : head_ent;
`else
    assign byp     = 1'b0;
    assign out_ent = head_ent;
`endif

    assign InReady  = ~full;
    assign OutValid = ~empty | byp;
    assign enq      = InValid & ~full & ~Flush & ~byp;
    assign deq      = ~empty & OutReady & ~Flush;

    assign OutFpRes  = out_ent.fp_res;
    assign OutIntRes = out_ent.int_res;
    assign OutToInt  = out_ent.to_int;
    assign OutNV     = out_ent.nv;
    assign OutRd     = out_ent.rd;
    assign StickyNV  = sticky_q;
    assign Count     = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // Set has priority over the CSR clear.
        if (StickyClr) sticky_d = 1'b0;
        if ((deq & head_ent.nv) | (byp & InNV)) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= in_ent;
    end

endmodule

// File: tb/tb_fcmp_wb_buffer.sv
// Directed table-driven bench for fcmp_wb_buffer at DEPTH=2, plus hand sequences for stream, bypass and reset.
module tb_fcmp_wb_buffer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        InValid, InReady, InToInt, InNV, Flush, OutValid, OutReady;
    logic        OutToInt, OutNV, StickyNV, StickyClr;
    logic [63:0] InFpRes, InIntRes, OutFpRes, OutIntRes;
    logic [4:0]  InRd, OutRd;
    logic [1:0]  Count;

    int checks   = 0;
    int failures = 0;

    fcmp_wb_buffer #(.FLEN(64), .XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .InValid(InValid), .InReady(InReady), .InFpRes(InFpRes), .InIntRes(InIntRes),
        .InToInt(InToInt), .InNV(InNV), .InRd(InRd), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .OutFpRes(OutFpRes), .OutIntRes(OutIntRes),
        .OutToInt(OutToInt), .OutRd(OutRd), .OutNV(OutNV),
        .StickyNV(StickyNV), .StickyClr(StickyClr), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;  logic [63:0] fp; logic [63:0] ir; logic ti; logic nv; logic [4:0] rd;
        logic        fl;  logic ordy; logic sclr;
        logic        e_ov; logic e_ir; logic [1:0] e_cnt; logic e_st; logic chk;
        logic [63:0] e_fp; logic [63:0] e_int; logic e_ti; logic e_nv; logic [4:0] e_rd;
    } vec_t;

    localparam logic [63:0] A = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] B = 64'h4000_0000_0000_0000;
    localparam logic [63:0] C = 64'h4008_0000_0000_0000;
    localparam logic [63:0] Q = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] E = 64'h4010_0000_0000_0000;
    localparam logic [63:0] F = 64'h4014_0000_0000_0000;
    localparam logic [63:0] G = 64'h4018_0000_0000_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        InValid = 0; InFpRes = '0; InIntRes = '0; InToInt = 0; InNV = 0; InRd = '0;
        Flush = 0; OutReady = 0; StickyClr = 0;
    endtask

    vec_t tbl [18];

    initial begin
        logic exp_ov;
        logic [1:0] exp_cnt;
        //          iv fp ir ti nv rd fl or sc | ov ir cnt st chk e_fp e_int ti nv rd
        tbl[0]  = '{1, A, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, B, 0, 0, 0, 2, 0, 0, 0,   1, 1, 1, 0, 1, A, 0, 0, 0, 1};
        tbl[2]  = '{1, C, 0, 0, 0, 3, 0, 0, 0,   1, 0, 2, 0, 1, A, 0, 0, 0, 1};
        tbl[3]  = '{1, C, 0, 0, 0, 3, 0, 1, 0,   1, 0, 2, 0, 1, A, 0, 0, 0, 1};
        tbl[4]  = '{1, C, 0, 0, 0, 3, 0, 1, 0,   1, 1, 1, 0, 1, B, 0, 0, 0, 2};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 1, C, 0, 0, 0, 3};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 1, 1, 4, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1,   1, 1, 1, 0, 1, 0, 1, 1, 1, 4};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, Q, 0, 0, 1, 5, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1, E, 0, 0, 0, 6, 0, 0, 0,   1, 1, 1, 0, 1, Q, 0, 0, 1, 5};
        tbl[13] = '{1, F, 0, 0, 0, 7, 1, 1, 0,   1, 0, 2, 0, 1, Q, 0, 0, 1, 5};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{1, G, 0, 0, 0, 8, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 1, G, 0, 0, 0, 8};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        idle_inputs();
        reset_n = 0;
        #2;
        chk("reset_ov", OutValid, 0);
        chk("reset_ir", InReady, 1);
        chk("reset_cnt", Count, 0);
        chk("reset_st", StickyNV, 0);
        #10 reset_n = 1;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            InValid = tbl[i].iv; InFpRes = tbl[i].fp; InIntRes = tbl[i].ir; InToInt = tbl[i].ti;
            InNV = tbl[i].nv; InRd = tbl[i].rd; Flush = tbl[i].fl; OutReady = tbl[i].ordy;
            StickyClr = tbl[i].sclr;
            @(negedge clk);
            chk($sformatf("row%0d_ov", i), OutValid, tbl[i].e_ov);
            chk($sformatf("row%0d_ir", i), InReady, tbl[i].e_ir);
            chk($sformatf("row%0d_cnt", i), Count, tbl[i].e_cnt);
            chk($sformatf("row%0d_st", i), StickyNV, tbl[i].e_st);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d_fp", i), OutFpRes, tbl[i].e_fp);
                chk($sformatf("row%0d_int", i), OutIntRes, tbl[i].e_int);
                chk($sformatf("row%0d_ti", i), OutToInt, tbl[i].e_ti);
                chk($sformatf("row%0d_nv", i), OutNV, tbl[i].e_nv);
                chk($sformatf("row%0d_rd", i), OutRd, tbl[i].e_rd);
            end
        end

        // Continuous stream across pointer wrap with a always-ready consumer.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            InValid = (i < 10); InFpRes = 64'h1000 + 64'(i); InRd = 5'(i); OutReady = 1;
            @(negedge clk);
`ifdef FCMP_WB_BYPASS_EN
            exp_ov  = (i < 10);
            exp_cnt = 2'd0;
            if (exp_ov) chk($sformatf("stream%0d_fp", i), OutFpRes, 64'h1000 + 64'(i));
`else
            exp_ov  = (i >= 1) && (i <= 10);
            exp_cnt = exp_ov ? 2'd1 : 2'd0;
            if (exp_ov) chk($sformatf("stream%0d_fp", i), OutFpRes, 64'h1000 + 64'(i - 1));
`endif
            chk($sformatf("stream%0d_ov", i), OutValid, exp_ov);
            chk($sformatf("stream%0d_cnt", i), Count, exp_cnt);
            chk($sformatf("stream%0d_ir", i), InReady, 1);
        end

        // Single integer result into an empty buffer with the consumer ready.
        @(posedge clk); #1;
        idle_inputs();
        InValid = 1; InToInt = 1; InIntRes = 64'd1; InNV = 1; InRd = 5'd9; OutReady = 1;
        @(negedge clk);
`ifdef FCMP_WB_BYPASS_EN
        chk("byp_same_ov", OutValid, 1);
        chk("byp_same_int", OutIntRes, 64'd1);
`else
        chk("byp_same_ov", OutValid, 0);
`endif
        @(posedge clk); #1;
        InValid = 0;
        @(negedge clk);
`ifdef FCMP_WB_BYPASS_EN
        chk("byp_next_ov", OutValid, 0);
`else
        chk("byp_next_ov", OutValid, 1);
        chk("byp_next_int", OutIntRes, 64'd1);
        chk("byp_next_ti", OutToInt, 1);
`endif
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("byp_sticky", StickyNV, 1);
        chk("byp_cnt", Count, 0);

        // Reset asserted with two entries buffered.
        @(posedge clk); #1;
        InValid = 1; InFpRes = 64'd1;
        @(posedge clk); #1;
        InFpRes = 64'd2;
        @(posedge clk); #1;
        InValid = 0;
        @(negedge clk);
        chk("pre_rst_cnt", Count, 2);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_ov", OutValid, 0);
        chk("mid_rst_ir", InReady, 1);
        chk("mid_rst_cnt", Count, 0);
        chk("mid_rst_st", StickyNV, 0);
        #1 reset_n = 1;
        InValid = 1; InFpRes = 64'd3;
        @(posedge clk); #1;
        InValid = 0;
        @(negedge clk);
        chk("post_rst_cnt", Count, 1);
        chk("post_rst_ov", OutValid, 1);
        chk("post_rst_fp", OutFpRes, 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
